// File: rtl/router_out_arb_pkg.sv
// Shared constants and types for the router output-port arbiter: packet header
// field positions, input-direction indices and the output buffer state.
package router_out_arb_pkg;

  localparam int WIDTH_DEF  = 35;
  localparam int NUM_IN_DEF = 4;
  localparam int DEPTH_DEF  = 2;

  // Header fields are 2 bits each, located at pkt[WIDTH-<OFS> +: HDR_FIELD_W]
  localparam int HDR_FIELD_W = 2;
  localparam int HDR_W       = 8;
  localparam int SRC_X_OFS   = 2;
  localparam int SRC_Y_OFS   = 4;
  localparam int DST_X_OFS   = 6;
  localparam int DST_Y_OFS   = 8;

  localparam int DIR_W  = 0;
  localparam int DIR_N  = 1;
  localparam int DIR_S  = 2;
  localparam int DIR_PE = 3;

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_PARTIAL = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_e;

  function automatic buf_state_e buf_classify(input int count, input int depth);
    if (count == 0)
      return BUF_EMPTY;
    else if (count >= depth)
      return BUF_FULL;
    else
      return BUF_PARTIAL;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Circular packet buffer with registered head entry; push is ignored when full
// and pop is ignored when empty, so callers may drive them unqualified.
module pkt_fifo
  import router_out_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output buf_state_e       state_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        push_ok, pop_ok;

  assign push_ok = push_i && (count_q != FULL_CNT);
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok)
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads zero while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok)
        mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign state_o = buf_classify(int'(count_q), DEPTH);

endmodule

// File: rtl/router_out_arb.sv
// Output-port arbiter of a mesh router: round-robin grant among input
// directions into a small packet buffer that feeds the outgoing link.
module router_out_arb
  import router_out_arb_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             in_valid,
  input  logic [NUM_IN-1:0][WIDTH-1:0]  in_data,
  output logic [NUM_IN-1:0]             in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [15:0]                   fwd_count
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_IN - 1);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]      fwd_q, fwd_d;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] scan_idx;
  logic             gnt_found;
  logic             buf_full;
  logic             in_xfer;
  logic             out_xfer;
  buf_state_e       buf_state;

  // Scan from rr_ptr upward with wraparound; first active requester wins
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_IN);
      if (!gnt_found && in_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Readiness ignores out_ready: a full buffer never accepts, even if draining
  assign buf_full  = (buf_state == BUF_FULL);
  assign in_ready  = (!rst && !buf_full && gnt_found) ? (NUM_IN'(1) << gnt_idx) : '0;
  assign in_xfer   = |(in_valid & in_ready);
  assign out_valid = (buf_state != BUF_EMPTY);
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    fwd_d    = fwd_q;
    if (in_xfer)
      rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    if (out_xfer && (fwd_q != 16'hFFFF))
      fwd_d = fwd_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      fwd_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      fwd_q    <= fwd_d;
    end
  end

  pkt_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_xfer),
    .push_data_i (in_data[gnt_idx]),
    .pop_i       (out_ready),
    .head_o      (out_data),
    .state_o     (buf_state)
  );

  assign fwd_count = fwd_q;

endmodule

// File: tb/tb_router_out_arb.sv
// Randomized and directed bench for router_out_arb with a queue-based model
// of the arbiter and buffer; a separate monitor scores emitted packets.
module tb_router_out_arb;

  localparam int WIDTH  = 35;
  localparam int NUM_IN = 4;
  localparam int DEPTH  = 2;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [NUM_IN-1:0]            in_valid = '0;
  logic [NUM_IN-1:0][WIDTH-1:0] in_data = '0;
  logic [NUM_IN-1:0]            in_ready;
  logic                         out_valid;
  logic [WIDTH-1:0]             out_data;
  logic                         out_ready = 1'b0;
  logic [15:0]                  fwd_count;

  router_out_arb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .fwd_count (fwd_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               m_rr  = 0;
  int               m_fwd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One cycle of stimulus; the model predicts grant, readiness and counters.
  task automatic step(input logic [NUM_IN-1:0] v, input logic [NUM_IN-1:0][WIDTH-1:0] d,
                      input logic ordy, output logic [NUM_IN-1:0] got_rdy,
                      output logic [WIDTH-1:0] got_data, output int g);
    logic [NUM_IN-1:0] exp_rdy;
    int occ;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    occ = exp_q.size();
    g = -1;
    if (occ < DEPTH)
      for (int k = 0; k < NUM_IN; k++) begin
        int i;
        i = (m_rr + k) % NUM_IN;
        if (g < 0 && v[i]) g = i;
      end
    exp_rdy = (g >= 0) ? NUM_IN'(1 << g) : '0;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(occ != 0));
    chk("fwd_count", 64'(fwd_count), 64'(m_fwd));
    got_rdy  = in_ready;
    got_data = out_data;
    if (g >= 0) begin
      exp_q.push_back(d[g]);
      m_rr = (g + 1) % NUM_IN;
    end
    if (occ != 0 && ordy && m_fwd < 65535)
      m_fwd++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = '1;
    out_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_fwd_count", 64'(fwd_count), 64'd0);
    exp_q.delete();
    m_rr  = 0;
    m_fwd = 0;
    @(negedge clk);
    in_valid = '0;
    #3 rst = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rnd_pkt();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[WIDTH-1:0];
  endfunction

  // Monitor: scores each packet the DUT presents on a handshake cycle
  logic             held = 1'b0;
  logic [WIDTH-1:0] held_data = '0;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held)
        chk("out_data_stable", 64'(out_data), 64'(held_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("unexpected_packet", 64'(out_data), 64'd0 - 64'd1);
        else
          chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  initial begin
    logic [NUM_IN-1:0]            rdy;
    logic [WIDTH-1:0]             od;
    logic [NUM_IN-1:0][WIDTH-1:0] d;
    logic [WIDTH-1:0]             pk [3];
    int g;
    int p;

    #2;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_in_ready", 64'(in_ready), 64'd0);
    chk("init_out_data", 64'(out_data), 64'd0);
    chk("init_fwd_count", 64'(fwd_count), 64'd0);
    #11 rst = 1'b0;

    // Single packet from requester 0
    d = '0;
    d[0] = 35'h1_2345_6789;
    step(4'b0001, d, 1'b1, rdy, od, g);
    chk("single_in_ready", 64'(rdy), 64'b0001);
    step(4'b0000, d, 1'b1, rdy, od, g);
    chk("single_out_data", 64'(od), 64'h1_2345_6789);
    step(4'b0000, d, 1'b1, rdy, od, g);

    // Fairness with every requester active
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < NUM_IN; j++) d[j] = rnd_pkt();
      step(4'b1111, d, 1'b1, rdy, od, g);
      chk("fair_grant", 64'(rdy), 64'(1 << (k % 4)));
    end
    step(4'b0000, d, 1'b1, rdy, od, g);
    step(4'b0000, d, 1'b1, rdy, od, g);

    // Backpressure: three packets on requester 1 while downstream stalls
    pk[0] = 35'h4_AAAA_0001;
    pk[1] = 35'h4_BBBB_0002;
    pk[2] = 35'h4_CCCC_0003;
    p = 0;
    for (int c = 0; c < 6; c++) begin
      d = '0;
      d[1] = pk[(p < 3) ? p : 2];
      step((p < 3) ? 4'b0010 : 4'b0000, d, 1'b0, rdy, od, g);
      if (g == 1) p++;
    end
    chk("bp_full_in_ready", 64'(rdy), 64'd0);
    chk("bp_head_stable", 64'(od), 64'(pk[0]));
    for (int c = 0; c < 6; c++) begin
      d = '0;
      d[1] = pk[(p < 3) ? p : 2];
      step((p < 3) ? 4'b0010 : 4'b0000, d, 1'b1, rdy, od, g);
      if (g == 1) p++;
    end

    // Push and pop together with one packet resident
    d = '0;
    d[2] = rnd_pkt();
    step(4'b0100, d, 1'b0, rdy, od, g);
    for (int c = 0; c < 10; c++) begin
      d[2] = rnd_pkt();
      step(4'b0100, d, 1'b1, rdy, od, g);
    end
    step(4'b0000, d, 1'b1, rdy, od, g);

    // Reset with two packets buffered
    for (int c = 0; c < 2; c++) begin
      d[3] = rnd_pkt();
      step(4'b1000, d, 1'b0, rdy, od, g);
    end
    do_reset();
    for (int c = 0; c < 3; c++) step(4'b0000, d, 1'b1, rdy, od, g);
    step(4'b1111, d, 1'b1, rdy, od, g);
    chk("post_reset_grant", 64'(rdy), 64'b0001);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < NUM_IN; j++) d[j] = rnd_pkt();
      step(NUM_IN'($urandom), d, ($urandom_range(0, 3) != 0), rdy, od, g);
    end

    // Drive the forward counter into saturation
    for (int c = 0; c < 65545; c++) begin
      d[0] = rnd_pkt();
      step(4'b1111, d, 1'b1, rdy, od, g);
    end
    chk("fwd_saturated", 64'(fwd_count), 64'hFFFF);

    for (int c = 0; c < DEPTH + 2; c++) step(4'b0000, d, 1'b1, rdy, od, g);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/router_out_arb.md
ROUTER_OUT_ARB -- requirements
Module: router_out_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 35, packet width in bits.
REQ-002 The block SHALL have parameter NUM_IN, default 4, number of input-direction requesters (index 0..3 = W, N, S, PE for an East output port).
REQ-003 The block SHALL have parameter DEPTH, default 2, output buffer depth in packets.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port in_valid  input  NUM_IN  per-requester packet-valid.
REQ-007 Port in_data  input  NUM_IN x WIDTH  per-requester packet.
REQ-008 Port in_ready  output  NUM_IN  per-requester accept; at most one bit high.
REQ-009 Port out_valid  output  1  head packet valid toward link or next router.
REQ-010 Port out_data  output  WIDTH  head packet.
REQ-011 Port out_ready  input  1  downstream accept.
REQ-012 Port fwd_count  output  16  packets forwarded since reset, saturating.

Function
REQ-013 Packet header layout SHALL be src_x [WIDTH-1:WIDTH-2], src_y [WIDTH-3:WIDTH-4], dst_x [WIDTH-5:WIDTH-6], dst_y [WIDTH-7:WIDTH-8]; the block SHALL pass all WIDTH bits unmodified (coordinate update happens in the input-direction router).
REQ-014 A transfer on input i SHALL occur on a rising edge where in_valid[i] and in_ready[i] are both high; an output transfer where out_valid and out_ready are both high.
REQ-015 in_ready SHALL be combinational: one-hot on the granted requester when the buffer is not full and any in_valid is high, else all zero.
REQ-016 Grant SHALL be round-robin: search starts at pointer rr_ptr (2 bits) and wraps modulo NUM_IN; first requester with in_valid high wins.
REQ-017 After an accepted input transfer from i, rr_ptr SHALL become (i+1) mod NUM_IN; with no transfer rr_ptr SHALL hold.
REQ-018 The buffer SHALL be a circular FIFO of DEPTH entries with write pointer, read pointer and occupancy counter 0..DEPTH; buffer state EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
REQ-019 out_valid SHALL equal (occupancy != 0); out_data SHALL be the entry at the read pointer, registered (no combinational path from in_data).
REQ-020 Latency SHALL be one cycle: a packet accepted at edge N is on out_data with out_valid high after edge N when the buffer was empty.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order; pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 in_ready SHALL depend only on FULL, not on same-cycle out_ready (no pass-through when full).
REQ-023 out_data SHALL stay stable while out_valid is high and out_ready is low.
REQ-024 fwd_count SHALL increment on each output transfer and saturate at 16'hFFFF.
REQ-025 in_valid deasserting without a transfer SHALL cause no state change.

Reset
REQ-026 On rst high, immediately and regardless of clk: occupancy 0, pointers 0, rr_ptr 0, fwd_count 0, out_valid 0, in_ready all 0; out_data 0.
REQ-027 Reset asserted mid-operation SHALL discard buffered packets; none SHALL appear after deassertion.
REQ-028 First grant after reset SHALL start search at requester 0.

Structure
REQ-029 A shared package SHALL hold WIDTH default, header field bit-offset constants, and direction index constants (DIR_W=0, DIR_N=1, DIR_S=2, DIR_PE=3).
REQ-030 The FIFO SHALL be a sub-module named pkt_fifo (parameters WIDTH, DEPTH; push/pop/full/empty); the round-robin arbiter SHALL stay in router_out_arb.

Verification
REQ-031 Single packet: after reset, in_valid=4'b0001, in_data=35'h1_2345_6789, out_ready=1 -> in_ready=4'b0001 for one cycle, out_valid next cycle with identical data, fwd_count=1.
REQ-032 Fairness: all four in_valid held high, out_ready=1, 8 cycles -> grant order 0,1,2,3,0,1,2,3; fwd_count=8.
REQ-033 Backpressure: out_ready=0, in_valid=4'b0010 with packets A, B, C -> A,B accepted, in_ready=0 while FULL, out_data=A stable; out_ready=1 -> A, B, C emerge in order.
REQ-034 Simultaneous push/pop at occupancy 1 -> occupancy stays 1, order preserved over 10 consecutive packets.
REQ-035 Reset mid-operation with occupancy 2 -> out_valid drops asynchronously, no stale packet after release, rr_ptr=0.
REQ-036 Saturation: force 65 540 output transfers -> fwd_count holds 16'hFFFF.
